tone_detector: RTL and testbench



---
 rtl/tone_pkg.sv | 41 ++++
 rtl/tone_edge_sync.sv | 28 ++
 rtl/tone_detector.sv | 152 +++++++++++++++
 tb/tb_tone_detector.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared note definitions for the tone generators and the tone detector.
// The half-period table is in microseconds and is scaled by the clock rate.
package tone_pkg;

    typedef enum logic [2:0] {
        NOTE_C    = 3'd0,
        NOTE_D    = 3'd1,
        NOTE_E    = 3'd2,
        NOTE_F    = 3'd3,
        NOTE_G    = 3'd4,
        NOTE_A    = 3'd5,
        NOTE_B    = 3'd6,
        NOTE_NONE = 3'd7
    } note_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_e;

    localparam int NUM_NOTES = 7;

    function automatic int unsigned half_us(input note_e note);
        case (note)
            NOTE_C:  return 1911;
            NOTE_D:  return 1703;
            NOTE_E:  return 1517;
            NOTE_F:  return 1432;
            NOTE_G:  return 1276;
            NOTE_A:  return 1136;
            NOTE_B:  return 1012;
            default: return 0;
        endcase
    endfunction

    function automatic int unsigned expected_period(input note_e note, input int unsigned m);
        return 2 * m * half_us(note);
    endfunction

endpackage

// File: rtl/tone_edge_sync.sv
// Two-flop synchroniser for an asynchronous pin plus a one-cycle rising-edge pulse.
// rise is valid at the third clk edge after the pin goes high.
module tone_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/tone_detector.sv
// Measures the rise-to-rise period of a square-wave tone and locks onto the
// matching note after LOCK_N consecutive agreeing periods.
module tone_detector
    import tone_pkg::*;
#(
    parameter int M_HZ      = 20,
    parameter int CNT_W     = 20,
    parameter int TOL_SHIFT = 6,
    parameter int LOCK_N    = 3,
    parameter int TIMEOUT   = 100000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             audio_in,
    output logic [CNT_W-1:0] period,
    output logic             period_strobe,
    output logic             note_valid,
    output logic [2:0]       note_id
);

    localparam int EXP_W = CNT_W + 2;
    localparam int MC_W  = $clog2(LOCK_N + 1);

    logic rise;

    tone_edge_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (audio_in),
        .rise  (rise)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             strobe_q, strobe_d;
    logic [MC_W-1:0]  match_cnt_q, match_cnt_d;
    note_e            last_id_q, last_id_d;
    logic             valid_q, valid_d;
    note_e            note_id_q, note_id_d;

    // Parallel tolerance check against every table entry.
    logic [NUM_NOTES-1:0] hit;
    logic [EXP_W-1:0]     period_x;
    logic                 match_any;
    note_e                match_id;

    assign period_x = EXP_W'(period_q);

    for (genvar gi = 0; gi < NUM_NOTES; gi++) begin : g_match
        localparam logic [EXP_W-1:0] EXP_P = EXP_W'(expected_period(note_e'(3'(gi)), M_HZ));
        localparam logic [EXP_W-1:0] TOL   = EXP_P >> TOL_SHIFT;
        logic [EXP_W-1:0] diff;
        assign diff    = (period_x >= EXP_P) ? (period_x - EXP_P) : (EXP_P - period_x);
        assign hit[gi] = (diff <= TOL);
    end

    always_comb begin
        match_id = NOTE_NONE;
        for (int i = 0; i < NUM_NOTES; i++) begin
            if (hit[i]) match_id = note_e'(3'(i));
        end
    end

    assign match_any = |hit;

    logic [MC_W-1:0] mc_next;

    always_comb begin
        state_d     = state_q;
        cnt_d       = (cnt_q < CNT_W'(TIMEOUT)) ? cnt_q + 1'b1 : cnt_q;
        period_d    = period_q;
        strobe_d    = 1'b0;
        match_cnt_d = match_cnt_q;
        last_id_d   = last_id_q;
        valid_d     = valid_q;
        note_id_d   = note_id_q;
        mc_next     = '0;

        if (rise) cnt_d = CNT_W'(1);

        if (!enable) begin
            state_d     = ST_IDLE;
            match_cnt_d = '0;
            valid_d     = 1'b0;
            note_id_d   = NOTE_NONE;
        end else if (rise) begin
            // The first edge only arms the measurement; later edges close a period.
            if (state_q == ST_IDLE) begin
                state_d = ST_MEASURE;
            end else begin
                period_d = cnt_q;
                strobe_d = 1'b1;
            end
        end else if (state_q != ST_IDLE && cnt_q == CNT_W'(TIMEOUT)) begin
            state_d     = ST_IDLE;
            match_cnt_d = '0;
            valid_d     = 1'b0;
            note_id_d   = NOTE_NONE;
        end

        if (enable && strobe_q && state_q != ST_IDLE) begin
            if (match_any) begin
                if (match_id == last_id_q) begin
                    mc_next = (match_cnt_q >= MC_W'(LOCK_N)) ? match_cnt_q : match_cnt_q + 1'b1;
                end else begin
                    last_id_d = match_id;
                    mc_next   = MC_W'(1);
                end
            end
            match_cnt_d = mc_next;
            if (mc_next == MC_W'(LOCK_N)) begin
                state_d   = ST_LOCKED;
                valid_d   = 1'b1;
                note_id_d = last_id_d;
            end else begin
                state_d   = ST_MEASURE;
                valid_d   = 1'b0;
                note_id_d = NOTE_NONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            period_q    <= '0;
            strobe_q    <= 1'b0;
            match_cnt_q <= '0;
            last_id_q   <= NOTE_NONE;
            valid_q     <= 1'b0;
            note_id_q   <= NOTE_NONE;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            period_q    <= period_d;
            strobe_q    <= strobe_d;
            match_cnt_q <= match_cnt_d;
            last_id_q   <= last_id_d;
            valid_q     <= valid_d;
            note_id_q   <= note_id_d;
        end
    end

    assign period        = period_q;
    assign period_strobe = strobe_q;
    assign note_valid    = valid_q;
    assign note_id       = note_id_q;

endmodule

// File: tb/tb_tone_detector.sv
// Directed bench for tone_detector at 1 MHz with a 5000-cycle silence timeout.
module tb_tone_detector;

    localparam int CNT_W = 20;

    logic             clk;
    logic             rst_n;
    logic             enable;
    logic             audio_in;
    logic [CNT_W-1:0] period;
    logic             period_strobe;
    logic             note_valid;
    logic [2:0]       note_id;

    int checks = 0;
    int errors = 0;

    tone_detector #(
        .M_HZ      (1),
        .CNT_W     (CNT_W),
        .TOL_SHIFT (6),
        .LOCK_N    (3),
        .TIMEOUT   (5000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .audio_in      (audio_in),
        .period        (period),
        .period_strobe (period_strobe),
        .note_valid    (note_valid),
        .note_id       (note_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One full pin period of p cycles. Checks the strobe/period three edges after
    // the pin rises (that strobe closes the previous period) and the lock state one
    // edge later.
    task automatic wave(input int p, input int e_stb, input int e_per,
                        input int e_vld, input int e_id, input string tag);
        audio_in = 1'b1;
        repeat (3) tick();
        chk({tag, ".strobe"}, 32'(period_strobe), e_stb);
        chk({tag, ".period"}, 32'(period), e_per);
        tick();
        chk({tag, ".valid"}, 32'(note_valid), e_vld);
        chk({tag, ".id"}, 32'(note_id), e_id);
        $display("%s: p=%0d strobe_seen=%0d period=%0d valid=%0b id=%0d",
                 tag, p, e_stb, period, note_valid, note_id);
        repeat (p / 2 - 4) tick();
        audio_in = 1'b0;
        repeat (p - p / 2) tick();
    endtask

    initial begin
        rst_n    = 1'b0;
        enable   = 1'b1;
        audio_in = 1'b0;

        for (int i = 0; i < 4; i++) begin
            audio_in = ~audio_in;
            tick();
        end
        chk("rst.period", 32'(period), 0);
        chk("rst.strobe", 32'(period_strobe), 0);
        chk("rst.valid", 32'(note_valid), 0);
        chk("rst.id", 32'(note_id), 7);
        $display("reset: period=%0d valid=%0b id=%0d", period, note_valid, note_id);

        audio_in = 1'b0;
        rst_n    = 1'b1;
        repeat (4) tick();
        chk("idle.strobe", 32'(period_strobe), 0);

        // D lock: first edge arms, lock after the third matching period
        wave(3406, 0, 0,    0, 7, "d1");
        wave(3406, 1, 3406, 0, 7, "d2");
        wave(3406, 1, 3406, 0, 7, "d3");
        wave(3406, 1, 3406, 1, 1, "d4");
        // Tolerance band edges for D (3406 +/- 53)
        wave(3459, 1, 3406, 1, 1, "d5");
        wave(3460, 1, 3459, 1, 1, "tol_in");
        wave(3406, 1, 3460, 0, 7, "tol_out");
        wave(3406, 1, 3406, 0, 7, "relock1");
        wave(3406, 1, 3406, 0, 7, "relock2");
        wave(3034, 1, 3406, 1, 1, "relock3");
        // Switch to E
        wave(3034, 1, 3034, 0, 7, "e1");
        wave(3034, 1, 3034, 0, 7, "e2");
        wave(3034, 1, 3034, 1, 2, "e3");

        // Disable mid-lock
        enable = 1'b0;
        tick();
        chk("dis.valid", 32'(note_valid), 0);
        chk("dis.id", 32'(note_id), 7);
        chk("dis.strobe", 32'(period_strobe), 0);
        $display("disable: valid=%0b id=%0d", note_valid, note_id);
        wave(3034, 0, 3034, 0, 7, "dis_wave");
        enable = 1'b1;
        wave(2272, 0, 3034, 0, 7, "en1");
        wave(2272, 1, 2272, 0, 7, "en2");
        wave(2272, 1, 2272, 0, 7, "en3");
        wave(2272, 1, 2272, 1, 5, "en4");

        // Timeout: last rise, then silence
        audio_in = 1'b1;
        repeat (3) tick();
        chk("to.strobe", 32'(period_strobe), 1);
        chk("to.period", 32'(period), 2272);
        tick();
        chk("to.valid_hold", 32'(note_valid), 1);
        repeat (1132) tick();
        audio_in = 1'b0;
        repeat (3866) tick();
        chk("to.pre_valid", 32'(note_valid), 1);
        chk("to.pre_id", 32'(note_id), 5);
        tick();
        chk("to.valid", 32'(note_valid), 0);
        chk("to.id", 32'(note_id), 7);
        chk("to.period_hold", 32'(period), 2272);
        $display("timeout: valid=%0b id=%0d period=%0d", note_valid, note_id, period);
        wave(2272, 0, 2272, 0, 7, "post_to1");

        audio_in = 1'b1;
        repeat (3) tick();
        chk("post_to2.strobe", 32'(period_strobe), 1);
        chk("post_to2.period", 32'(period), 2272);
        tick();
        chk("post_to2.valid", 32'(note_valid), 0);
        $display("post_to2: period=%0d valid=%0b", period, note_valid);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
